// File: rtl/switch_pkg.sv
// Shared types and constants for the packet switch core.
package switch_pkg;

  typedef enum logic [1:0] {
    CAUSE_NOMATCH = 2'd0,
    CAUSE_NOSPACE = 2'd1,
    CAUSE_LEN     = 2'd2,
    CAUSE_FCS     = 2'd3
  } drop_cause_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SA,
    ST_LEN,
    ST_BODY,
    ST_DISCARD
  } state_e;

  // Header byte offsets within a packet
  localparam int unsigned OFF_DA   = 0;
  localparam int unsigned OFF_SA   = 1;
  localparam int unsigned OFF_LEN  = 2;
  // DA + SA + LEN + FCS
  localparam int unsigned OVERHEAD = 4;

endpackage

// File: rtl/pkt_fifo.sv
// Per-port store-and-forward FIFO: writes are speculative until commit;
// rollback discards everything written since the last commit.
module pkt_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 64,
  localparam int unsigned AW_F      = $clog2(FIFO_DEPTH),
  localparam int unsigned CW        = AW_F + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              commit,
  input  logic              rollback,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [CW-1:0]     free_cnt,
  output logic [CW-1:0]     cmt_cnt
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [CW-1:0]     wr_ptr;
  logic [CW-1:0]     cmt_ptr;
  logic [CW-1:0]     rd_ptr;
  logic              rd_fire;

  // Free space excludes both committed and speculative bytes
  assign cmt_cnt  = cmt_ptr - rd_ptr;
  assign free_cnt = CW'(FIFO_DEPTH) - (wr_ptr - rd_ptr);
  assign rd_fire  = rd_en && (cmt_cnt != '0);

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr[AW_F-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      cmt_ptr <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (rollback) begin
        wr_ptr <= cmt_ptr;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + CW'(1);
      end
      if (commit) begin
        cmt_ptr <= wr_ptr;
      end
      if (rd_fire) begin
        rd_data <= mem[rd_ptr[AW_F-1:0]];
        rd_ptr  <= rd_ptr + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pkt_switch_core.sv
// Packet switch core: address-table lookup, header/length/FCS checking
// and routing of byte-serial packets into per-port commit/rollback FIFOs.
module pkt_switch_core
  import switch_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned AW         = $clog2(NUM_PORTS)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        mem_en,
  input  logic                        mem_rd_wr,
  input  logic [AW-1:0]               mem_add,
  input  logic [DATA_W-1:0]           mem_data,
  input  logic                        data_status,
  input  logic [DATA_W-1:0]           data_in,
  output logic [NUM_PORTS-1:0]        ready,
  input  logic [NUM_PORTS-1:0]        read,
  output logic [NUM_PORTS*DATA_W-1:0] data_out,
  output logic                        drop_pulse,
  output logic [1:0]                  drop_cause
);

  localparam int unsigned AW_F = $clog2(FIFO_DEPTH);
  localparam int unsigned CW   = AW_F + 1;
  localparam int unsigned LW   = ((DATA_W > CW) ? DATA_W : CW) + 1;

  logic [DATA_W-1:0]    tbl [NUM_PORTS];
  state_e               state;
  logic                 armed;
  logic [AW-1:0]        tgt;
  logic [LW-1:0]        cnt;
  logic [LW-1:0]        need_q;
  logic [DATA_W-1:0]    xr;
  drop_cause_e          cause_q;

  logic                 match_c;
  logic [AW-1:0]        match_idx_c;
  logic [LW-1:0]        need_c;
  logic                 nospace_c;
  logic [AW-1:0]        wr_port_c;
  logic                 wr_go_c;
  logic                 cm_go_c;
  logic                 rb_go_c;
  logic [NUM_PORTS-1:0] wr_en_c;
  logic [NUM_PORTS-1:0] commit_c;
  logic [NUM_PORTS-1:0] rollback_c;

  logic [CW-1:0]        free_cnt [NUM_PORTS];
  logic [CW-1:0]        cmt_cnt  [NUM_PORTS];

  // Lowest matching table index wins: scan from the top down
  always_comb begin
    match_c     = 1'b0;
    match_idx_c = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (tbl[i] == data_in) begin
        match_c     = 1'b1;
        match_idx_c = AW'(i);
      end
    end
  end

  assign need_c    = LW'(data_in) + LW'(OVERHEAD);
  assign nospace_c = (need_c > LW'(FIFO_DEPTH)) || (need_c > LW'(free_cnt[tgt]));

  // FIFO strobes; the DA byte is written before the target is latched
  always_comb begin
    wr_go_c    = 1'b0;
    cm_go_c    = 1'b0;
    rb_go_c    = 1'b0;
    wr_port_c  = tgt;
    wr_en_c    = '0;
    commit_c   = '0;
    rollback_c = '0;
    case (state)
      ST_IDLE: begin
        if (armed && data_status && match_c) begin
          wr_go_c   = 1'b1;
          wr_port_c = match_idx_c;
        end
      end
      ST_SA: begin
        wr_go_c = data_status;
        rb_go_c = !data_status;
      end
      ST_LEN: begin
        wr_go_c = data_status && !nospace_c;
        rb_go_c = !data_status;
      end
      ST_BODY: begin
        if (data_status) begin
          wr_go_c = (cnt != need_q);
        end else if ((cnt == need_q) && (xr == '0)) begin
          cm_go_c = 1'b1;
        end else begin
          rb_go_c = 1'b1;
        end
      end
      ST_DISCARD: rb_go_c = !data_status;
      default: ;
    endcase
    for (int p = 0; p < NUM_PORTS; p++) begin
      wr_en_c[p]    = wr_go_c && (wr_port_c == AW'(p));
      commit_c[p]   = cm_go_c && (tgt == AW'(p));
      rollback_c[p] = rb_go_c && (tgt == AW'(p));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      armed      <= 1'b0;
      tgt        <= '0;
      cnt        <= '0;
      need_q     <= '0;
      xr         <= '0;
      cause_q    <= CAUSE_NOMATCH;
      drop_pulse <= 1'b0;
      drop_cause <= 2'd0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        tbl[i] <= DATA_W'(i);
      end
    end else begin
      drop_pulse <= 1'b0;
      if (mem_en && mem_rd_wr && (32'(mem_add) < NUM_PORTS)) begin
        tbl[mem_add] <= mem_data;
      end
      // A packet cut by reset is ignored until the line goes idle once
      if (!data_status) begin
        armed <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (armed && data_status) begin
            xr  <= data_in;
            cnt <= LW'(OFF_DA + 1);
            if (match_c) begin
              tgt   <= match_idx_c;
              state <= ST_SA;
            end else begin
              cause_q <= CAUSE_NOMATCH;
              state   <= ST_DISCARD;
            end
          end
        end
        ST_SA: begin
          if (data_status) begin
            xr    <= xr ^ data_in;
            cnt   <= LW'(OFF_SA + 1);
            state <= ST_LEN;
          end else begin
            drop_pulse <= 1'b1;
            drop_cause <= CAUSE_LEN;
            state      <= ST_IDLE;
          end
        end
        ST_LEN: begin
          if (!data_status) begin
            drop_pulse <= 1'b1;
            drop_cause <= CAUSE_LEN;
            state      <= ST_IDLE;
          end else if (nospace_c) begin
            cause_q <= CAUSE_NOSPACE;
            state   <= ST_DISCARD;
          end else begin
            xr     <= xr ^ data_in;
            cnt    <= LW'(OFF_LEN + 1);
            need_q <= need_c;
            state  <= ST_BODY;
          end
        end
        ST_BODY: begin
          if (data_status) begin
            if (cnt == need_q) begin
              cause_q <= CAUSE_LEN;
              state   <= ST_DISCARD;
            end else begin
              xr  <= xr ^ data_in;
              cnt <= cnt + LW'(1);
            end
          end else begin
            state <= ST_IDLE;
            if ((cnt != need_q) || (xr != '0)) begin
              drop_pulse <= 1'b1;
              drop_cause <= (cnt != need_q) ? CAUSE_LEN : CAUSE_FCS;
            end
          end
        end
        ST_DISCARD: begin
          if (!data_status) begin
            drop_pulse <= 1'b1;
            drop_cause <= cause_q;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    pkt_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .wr_en    (wr_en_c[p]),
      .wr_data  (data_in),
      .commit   (commit_c[p]),
      .rollback (rollback_c[p]),
      .rd_en    (read[p]),
      .rd_data  (data_out[p*DATA_W +: DATA_W]),
      .free_cnt (free_cnt[p]),
      .cmt_cnt  (cmt_cnt[p])
    );
    assign ready[p] = (cmt_cnt[p] != '0);
  end

endmodule
